accum_rd_seq: RTL and testbench

- Sequencer directly upstream of the accumulator-table read address control.
- On a start pulse it walks every output sub-matrix and every sub-row of each sub-matrix.
- It drives the per-column (sub_row, submat_m, submat_n) tuples consumed by the read address control, plus a per-column valid.
- Column c is skewed c cycles behind column 0, matching the diagonal drain of the systolic array.

---
 rtl/accum_pkg.sv | 19 +
 rtl/accum_rd_skew.sv | 55 +++++
 rtl/accum_rd_seq.sv | 167 ++++++++++++++++
 tb/tb_accum_rd_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared constants and state type for the accumulator-table read sequencer.
package accum_pkg;
    localparam int MAX_OUT_ROWS   = 128;
    localparam int MAX_OUT_COLS   = 128;
    localparam int SYS_ARR_ROWS   = 16;
    localparam int SYS_ARR_COLS   = 16;
    localparam int NUM_SUBMATS_M  = MAX_OUT_ROWS / SYS_ARR_ROWS;
    localparam int NUM_SUBMATS_N  = MAX_OUT_COLS / SYS_ARR_COLS;
    localparam int NUM_ACCUM_ROWS = NUM_SUBMATS_M * NUM_SUBMATS_N * SYS_ARR_ROWS;
    localparam int SUB_ROW_W      = $clog2(SYS_ARR_ROWS);
    localparam int SUBMAT_M_W     = $clog2(NUM_SUBMATS_M);
    localparam int SUBMAT_N_W     = $clog2(NUM_SUBMATS_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;
endpackage

// File: rtl/accum_rd_skew.sv
// Diagonal skew line: lane c carries the lane-0 tuple delayed by c cycles.
module accum_rd_skew #(
    parameter int LANES = 16,
    parameter int RW    = 4,
    parameter int MW    = 3,
    parameter int NW    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_v,
    input  logic [RW-1:0]              in_r,
    input  logic [MW-1:0]              in_m,
    input  logic [NW-1:0]              in_n,
    output logic [LANES-1:0]           out_v,
    output logic [LANES-1:0][RW-1:0]   out_r,
    output logic [LANES-1:0][MW-1:0]   out_m,
    output logic [LANES-1:0][NW-1:0]   out_n
);
    // Index i of these registers holds lane i+1.
    logic [LANES-2:0]           v_q;
    logic [LANES-2:0][RW-1:0]   r_q;
    logic [LANES-2:0][MW-1:0]   m_q;
    logic [LANES-2:0][NW-1:0]   n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            r_q <= '0;
            m_q <= '0;
            n_q <= '0;
        end else if (flush) begin
            v_q <= '0;
            r_q <= '0;
            m_q <= '0;
            n_q <= '0;
        end else begin
            for (int c = LANES - 2; c > 0; c--) begin
                v_q[c] <= v_q[c-1];
                r_q[c] <= r_q[c-1];
                m_q[c] <= m_q[c-1];
                n_q[c] <= n_q[c-1];
            end
            v_q[0] <= in_v;
            r_q[0] <= in_r;
            m_q[0] <= in_m;
            n_q[0] <= in_n;
        end
    end

    assign out_v = {v_q, in_v};
    assign out_r = {r_q, in_r};
    assign out_m = {m_q, in_m};
    assign out_n = {n_q, in_n};
endmodule

// File: rtl/accum_rd_seq.sv
// Sweeps every (sub-matrix, sub-row) on start and feeds skewed per-lane
// read tuples to the accumulator-table read address control.
module accum_rd_seq #(
    parameter  int MAX_OUT_ROWS = 128,
    parameter  int MAX_OUT_COLS = 128,
    parameter  int SYS_ARR_ROWS = 16,
    parameter  int SYS_ARR_COLS = 16,
    localparam int NSM = MAX_OUT_ROWS / SYS_ARR_ROWS,
    localparam int NSN = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int RW  = $clog2(SYS_ARR_ROWS),
    localparam int MW  = $clog2(NSM),
    localparam int NW  = $clog2(NSN),
    localparam int CMW = MW + 1,
    localparam int CNW = NW + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CMW-1:0]               num_submat_m,
    input  logic [CNW-1:0]               num_submat_n,
    output logic [RW*SYS_ARR_COLS-1:0]   sub_rows,
    output logic [MW*SYS_ARR_COLS-1:0]   submats_m,
    output logic [NW*SYS_ARR_COLS-1:0]   submats_n,
    output logic [SYS_ARR_COLS-1:0]      rd_valid,
    output logic                         busy,
    output logic                         done
);
    import accum_pkg::*;

    localparam int DW = (SYS_ARR_COLS > 2) ? $clog2(SYS_ARR_COLS) : 1;

    seq_state_t     state_q, state_d;
    logic [CMW-1:0] num_m_q, num_m_d, num_m_sat;
    logic [CNW-1:0] num_n_q, num_n_d, num_n_sat;
    logic           v_q, v_d;
    logic [RW-1:0]  r_q, r_d;
    logic [MW-1:0]  m_q, m_d;
    logic [NW-1:0]  n_q, n_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;
    logic           busy_d, done_d, flush, last;

    assign num_m_sat = (num_submat_m > CMW'(NSM)) ? CMW'(NSM) : num_submat_m;
    assign num_n_sat = (num_submat_n > CNW'(NSN)) ? CNW'(NSN) : num_submat_n;

    assign last = (r_q == RW'(SYS_ARR_ROWS - 1)) &&
                  (n_q == NW'(num_n_q - 1'b1)) &&
                  (m_q == MW'(num_m_q - 1'b1));

    always_comb begin
        state_d = state_q;
        num_m_d = num_m_q;
        num_n_d = num_n_q;
        v_d     = v_q;
        r_d     = r_q;
        m_d     = m_q;
        n_d     = n_q;
        dcnt_d  = dcnt_q;
        done_d  = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_m_d = num_m_sat;
                    num_n_d = num_n_sat;
                    // An empty sweep finishes at once without ever going busy.
                    if (num_m_sat == '0 || num_n_sat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        v_d     = 1'b1;
                        r_d     = '0;
                        m_d     = '0;
                        n_d     = '0;
                    end
                end
            end
            RUN: begin
                if (abort || last) begin
                    v_d   = 1'b0;
                    r_d   = '0;
                    m_d   = '0;
                    n_d   = '0;
                    flush = abort;
                    if (abort) begin
                        state_d = IDLE;
                    end else if (SYS_ARR_COLS == 1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        dcnt_d  = '0;
                    end
                end else if (r_q == RW'(SYS_ARR_ROWS - 1)) begin
                    r_d = '0;
                    if (n_q == NW'(num_n_q - 1'b1)) begin
                        n_d = '0;
                        m_d = m_q + 1'b1;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            DRAIN: begin
                // Wait for the last lane to emit its final tuple.
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (dcnt_q == DW'(SYS_ARR_COLS - 2)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            num_m_q <= '0;
            num_n_q <= '0;
            v_q     <= 1'b0;
            r_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            dcnt_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_m_q <= num_m_d;
            num_n_q <= num_n_d;
            v_q     <= v_d;
            r_q     <= r_d;
            m_q     <= m_d;
            n_q     <= n_d;
            dcnt_q  <= dcnt_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    accum_rd_skew #(
        .LANES (SYS_ARR_COLS),
        .RW    (RW),
        .MW    (MW),
        .NW    (NW)
    ) u_skew (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .in_v  (v_q),
        .in_r  (r_q),
        .in_m  (m_q),
        .in_n  (n_q),
        .out_v (rd_valid),
        .out_r (sub_rows),
        .out_m (submats_m),
        .out_n (submats_n)
    );
endmodule

// File: tb/tb_accum_rd_seq.sv
// Directed bench for accum_rd_seq: per-cycle comparison against a tuple-index model.
module tb_accum_rd_seq;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [3:0]   num_submat_m;
    logic [3:0]   num_submat_n;
    logic [63:0]  sub_rows;
    logic [47:0]  submats_m;
    logic [47:0]  submats_n;
    logic [15:0]  rd_valid;
    logic         busy;
    logic         done;

    int errs   = 0;
    int checks = 0;

    accum_rd_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .num_submat_m (num_submat_m),
        .num_submat_n (num_submat_n),
        .sub_rows     (sub_rows),
        .submats_m    (submats_m),
        .submats_n    (submats_n),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one start and check every output each cycle against the model.
    // m_eff/n_eff are the saturated counts; abort_at>0 aborts in that cycle.
    task automatic sweep(input int id, input logic [3:0] m_in, input logic [3:0] n_in,
                         input int m_eff, input int n_eff, input int abort_at,
                         input logic abort_with_start);
        int L, end_k;
        logic [15:0] ev;
        logic [63:0] er;
        logic [47:0] em, en;
        L = m_eff * n_eff * 16;
        end_k = (L == 0) ? 1 : ((abort_at > 0) ? abort_at + 8 : L + 16);
        start = 1'b1;
        abort = abort_with_start;
        num_submat_m = m_in;
        num_submat_n = n_in;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        num_submat_m = 4'd7;
        num_submat_n = 4'd7;
        for (int k = 1; k <= end_k; k++) begin
            @(negedge clk);
            ev = '0; er = '0; em = '0; en = '0;
            for (int c = 0; c < 16; c++) begin
                int t;
                t = k - c - 1;
                if (!(abort_at > 0 && k > abort_at) && t >= 0 && t < L) begin
                    ev[c] = 1'b1;
                    er[c*4 +: 4] = 4'(t % 16);
                    en[c*3 +: 3] = 3'((t / 16) % n_eff);
                    em[c*3 +: 3] = 3'(t / (16 * n_eff));
                end
            end
            chk($sformatf("s%0d k%0d rd_valid", id, k), 64'(rd_valid), 64'(ev));
            chk($sformatf("s%0d k%0d sub_rows", id, k), sub_rows, er);
            chk($sformatf("s%0d k%0d submats_m", id, k), 64'(submats_m), 64'(em));
            chk($sformatf("s%0d k%0d submats_n", id, k), 64'(submats_n), 64'(en));
            chk($sformatf("s%0d k%0d busy", id, k), 64'(busy),
                64'(!(abort_at > 0 && k > abort_at) && L > 0 && k <= L + 15));
            chk($sformatf("s%0d k%0d done", id, k), 64'(done),
                64'(!(abort_at > 0) && k == ((L == 0) ? 1 : L + 16)));
            // A start while busy must be ignored.
            if (L > 0 && k == 5) begin
                start = 1'b1;
                num_submat_m = 4'd1;
                num_submat_n = 4'd1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (abort_at > 0 && k == abort_at) begin
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        num_submat_m = 4'd1;
        num_submat_n = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d rd_valid", i), 64'(rd_valid), 64'd0);
            chk($sformatf("rst%0d sub_rows", i), sub_rows, 64'd0);
            chk($sformatf("rst%0d submats_m", i), 64'(submats_m), 64'd0);
            chk($sformatf("rst%0d submats_n", i), 64'(submats_n), 64'd0);
            chk($sformatf("rst%0d busy", i), 64'(busy), 64'd0);
            chk($sformatf("rst%0d done", i), 64'(done), 64'd0);
        end
        reset = 1'b0;
        sweep(1, 4'd1,  4'd1, 1, 1, 0,  1'b0);
        sweep(2, 4'd2,  4'd3, 2, 3, 0,  1'b0);
        sweep(3, 4'd0,  4'd5, 0, 5, 0,  1'b0);
        sweep(4, 4'd15, 4'd9, 8, 8, 0,  1'b0);
        sweep(5, 4'd1,  4'd1, 1, 1, 20, 1'b0);
        sweep(6, 4'd1,  4'd1, 1, 1, 0,  1'b0);
        sweep(7, 4'd1,  4'd2, 1, 2, 0,  1'b1);
        sweep(8, 4'd3,  4'd0, 3, 0, 0,  1'b0);
        @(negedge clk);
        chk("idle busy", 64'(busy), 64'd0);
        chk("idle done", 64'(done), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
